// File: rtl/mux2a1_ochobits_merge.sv
// Two-lane merge: lane 0 carries the even words of a stream and lane 1 the odd
// words. Each lane is buffered in a small FIFO, and the lanes are served
// strictly in turn so that the original word order is rebuilt on dataout.
module mux2a1_ochobits_merge #(
  parameter int unsigned DEPTH = 4  // per-lane entries, power of two, 2..16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid0,
  input  logic       valid1,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  output logic       validout,
  output logic [7:0] dataout,
  output logic       full0,
  output logic       full1,
  output logic       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [7:0]      mem0_q [DEPTH];
  logic [7:0]      mem1_q [DEPTH];

  logic [PtrW-1:0] wr_ptr0_q, wr_ptr0_d, rd_ptr0_q, rd_ptr0_d;
  logic [PtrW-1:0] wr_ptr1_q, wr_ptr1_d, rd_ptr1_q, rd_ptr1_d;
  logic [CntW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic            full0_q, full0_d, full1_q, full1_d;
  logic            sel_q, sel_d;
  logic            validout_q, validout_d;
  logic [7:0]      dataout_q, dataout_d;
  logic            overflow_q, overflow_d;

  logic            push0, push1, pop0, pop1;

  // Lane handshakes, pointer/count updates and merged-output selection.
  always_comb begin
    // A write is accepted only against the registered full flag, so a word
    // arriving at a full lane is dropped even if that lane pops this cycle.
    push0 = valid0 & ~full0_q;
    push1 = valid1 & ~full1_q;
    // Only the lane whose turn it is may be popped; the other one waits.
    pop0  = ~sel_q & (cnt0_q != '0);
    pop1  =  sel_q & (cnt1_q != '0);

    wr_ptr0_d  = wr_ptr0_q;
    rd_ptr0_d  = rd_ptr0_q;
    wr_ptr1_d  = wr_ptr1_q;
    rd_ptr1_d  = rd_ptr1_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    sel_d      = sel_q;
    validout_d = 1'b0;
    dataout_d  = dataout_q;
    overflow_d = overflow_q | (valid0 & full0_q) | (valid1 & full1_q);

    if (push0) wr_ptr0_d = wr_ptr0_q + PtrOne;
    if (push1) wr_ptr1_d = wr_ptr1_q + PtrOne;
    if (pop0)  rd_ptr0_d = rd_ptr0_q + PtrOne;
    if (pop1)  rd_ptr1_d = rd_ptr1_q + PtrOne;

    case ({push0, pop0})
      2'b10:   cnt0_d = cnt0_q + CntOne;
      2'b01:   cnt0_d = cnt0_q - CntOne;
      default: cnt0_d = cnt0_q;
    endcase
    case ({push1, pop1})
      2'b10:   cnt1_d = cnt1_q + CntOne;
      2'b01:   cnt1_d = cnt1_q - CntOne;
      default: cnt1_d = cnt1_q;
    endcase

    full0_d = (cnt0_d == CntFull);
    full1_d = (cnt1_d == CntFull);

    if (pop0) begin
      dataout_d  = mem0_q[rd_ptr0_q];
      validout_d = 1'b1;
      sel_d      = 1'b1;
    end else if (pop1) begin
      dataout_d  = mem1_q[rd_ptr1_q];
      validout_d = 1'b1;
      sel_d      = 1'b0;
    end
  end

  // Lane storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push0) mem0_q[wr_ptr0_q] <= data_in0;
    if (!reset && push1) mem1_q[wr_ptr1_q] <= data_in1;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr0_q  <= '0;
      rd_ptr0_q  <= '0;
      wr_ptr1_q  <= '0;
      rd_ptr1_q  <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      full0_q    <= 1'b0;
      full1_q    <= 1'b0;
      sel_q      <= 1'b0;
      validout_q <= 1'b0;
      dataout_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr0_q  <= wr_ptr0_d;
      rd_ptr0_q  <= rd_ptr0_d;
      wr_ptr1_q  <= wr_ptr1_d;
      rd_ptr1_q  <= rd_ptr1_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      full0_q    <= full0_d;
      full1_q    <= full1_d;
      sel_q      <= sel_d;
      validout_q <= validout_d;
      dataout_q  <= dataout_d;
      overflow_q <= overflow_d;
    end
  end

  assign validout = validout_q;
  assign dataout  = dataout_q;
  assign full0    = full0_q;
  assign full1    = full1_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mux2a1_ochobits_merge.sv
// Bench for the two-lane merge: a queue-based model plus directed scenarios
// with hand-computed literal expectations.
module tb_mux2a1_ochobits_merge;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic [7:0] data_in0 = 8'h00, data_in1 = 8'h00;
  logic       validout, full0, full1, overflow;
  logic [7:0] dataout;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  mux2a1_ochobits_merge #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid0   (valid0),
    .valid1   (valid1),
    .data_in0 (data_in0),
    .data_in1 (data_in1),
    .validout (validout),
    .dataout  (dataout),
    .full0    (full0),
    .full1    (full1),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: two word queues and a turn bit.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_sel = 1'b0;
  bit         m_v = 1'b0, m_f0 = 1'b0, m_f1 = 1'b0, m_ov = 1'b0;
  logic [7:0] m_d = 8'h00;

  task automatic model_edge();
    bit pre_f0, pre_f1;
    if (reset) begin
      q0.delete(); q1.delete();
      m_sel = 1'b0; m_v = 1'b0; m_d = 8'h00;
      m_f0 = 1'b0; m_f1 = 1'b0; m_ov = 1'b0;
    end else begin
      pre_f0 = (q0.size() == DEPTH);
      pre_f1 = (q1.size() == DEPTH);
      m_v = 1'b0;
      if (!m_sel && q0.size() > 0) begin
        m_d = q0.pop_front(); m_v = 1'b1; m_sel = 1'b1;
      end else if (m_sel && q1.size() > 0) begin
        m_d = q1.pop_front(); m_v = 1'b1; m_sel = 1'b0;
      end
      if (valid0) begin
        if (pre_f0) m_ov = 1'b1;
        else        q0.push_back(data_in0);
      end
      if (valid1) begin
        if (pre_f1) m_ov = 1'b1;
        else        q1.push_back(data_in1);
      end
      m_f0 = (q0.size() == DEPTH);
      m_f1 = (q1.size() == DEPTH);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model validout", 32'(validout), 32'(m_v));
      if (m_v) check("model dataout", 32'(dataout), 32'(m_d));
      check("model full0", 32'(full0), 32'(m_f0));
      check("model full1", 32'(full1), 32'(m_f1));
      check("model overflow", 32'(overflow), 32'(m_ov));
    end
  end

  // One clock edge with the given inputs; returns #1 after the edge.
  task automatic step(input logic r, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    @(negedge clk);
    reset = r; valid0 = v0; data_in0 = d0; valid1 = v1; data_in1 = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  logic [7:0] got[$];
  int         gaps;
  bit         any_full;

  task automatic rec();
    if (validout) got.push_back(dataout);
    else if (got.size() > 0 && got.size() < 24) gaps++;
    if (full0 || full1) any_full = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_on = 1'b1;
    check("rst validout", 32'(validout), 0);
    check("rst dataout", 32'(dataout), 0);
    check("rst full0", 32'(full0), 0);
    check("rst full1", 32'(full1), 0);
    check("rst overflow", 32'(overflow), 0);

    // Basic interleave
    step(1'b0, 1'b1, 8'h11, 1'b1, 8'h22);
    check("il e1 validout", 32'(validout), 0);
    idle();
    check("il e2 validout", 32'(validout), 1);
    check("il e2 dataout", 32'(dataout), 32'h11);
    step(1'b0, 1'b1, 8'h33, 1'b1, 8'h44);
    check("il e3 dataout", 32'(dataout), 32'h22);
    idle();
    check("il e4 dataout", 32'(dataout), 32'h33);
    idle();
    check("il e5 validout", 32'(validout), 1);
    check("il e5 dataout", 32'(dataout), 32'h44);
    idle();
    check("il e6 validout", 32'(validout), 0);
    check("il e6 dataout hold", 32'(dataout), 32'h44);

    // Out-of-turn stall
    do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hA5);
    idle();
    check("stall e2 validout", 32'(validout), 0);
    idle();
    check("stall e3 validout", 32'(validout), 0);
    step(1'b0, 1'b1, 8'h5A, 1'b0, 8'h00);
    check("stall e4 validout", 32'(validout), 0);
    idle();
    check("stall e5 dataout", 32'(dataout), 32'h5A);
    idle();
    check("stall e6 validout", 32'(validout), 1);
    check("stall e6 dataout", 32'(dataout), 32'hA5);

    // Overflow on lane 0
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 8'h00);
      if (i == 2) check("ovf first out", 32'(dataout), 32'h01);
      if (i == 4) check("ovf full0 early", 32'(full0), 0);
    end
    check("ovf full0", 32'(full0), 1);
    check("ovf no flag yet", 32'(overflow), 0);
    step(1'b0, 1'b1, 8'h06, 1'b0, 8'h00);
    check("ovf flag", 32'(overflow), 1);
    idle();
    check("ovf sticky", 32'(overflow), 1);
    check("ovf dataout hold", 32'(dataout), 32'h01);
    check("ovf full0 kept", 32'(full0), 1);

    // Simultaneous write and pop on a full lane
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 8'h00);
    check("wp full0", 32'(full0), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hB0);
    idle();
    check("wp lane1 out", 32'(dataout), 32'hB0);
    check("wp no ovf", 32'(overflow), 0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 8'h00);
    check("wp pop word", 32'(dataout), 32'hA1);
    check("wp ovf", 32'(overflow), 1);
    check("wp full0 cleared", 32'(full0), 0);

    // Wrap-around at half rate
    do_reset();
    got.delete(); gaps = 0; any_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'(2 * i), 1'b1, 8'(2 * i + 1));
      rec();
      idle();
      rec();
    end
    idle();
    rec();
    check("wrap count", 32'(got.size()), 24);
    for (int k = 0; k < got.size() && k < 24; k++) check("wrap word", 32'(got[k]), 32'(k));
    check("wrap gaps", 32'(gaps), 0);
    check("wrap full", 32'(any_full), 0);
    check("wrap overflow", 32'(overflow), 0);

    // Reset mid-stream
    do_reset();
    step(1'b0, 1'b1, 8'h31, 1'b1, 8'h32);
    step(1'b0, 1'b1, 8'h33, 1'b1, 8'h34);
    step(1'b0, 1'b1, 8'h35, 1'b1, 8'h36);
    step(1'b1, 1'b1, 8'hFF, 1'b0, 8'h00);
    check("mrst validout", 32'(validout), 0);
    check("mrst dataout", 32'(dataout), 0);
    check("mrst flags", 32'({full0, full1, overflow}), 0);
    step(1'b0, 1'b1, 8'h10, 1'b1, 8'h20);
    check("mrst e1 validout", 32'(validout), 0);
    idle();
    check("mrst first", 32'(dataout), 32'h10);
    idle();
    check("mrst second", 32'(dataout), 32'h20);
    idle();
    check("mrst drained", 32'(validout), 0);

    chk_on = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
